// File: rtl/minimips_dmem_arbiter_pkg.sv
// Shared types and constants for the MiniMIPS data-memory arbiter slice.
package minimips_pkg;

  // Arbiter sequencing states: one access walks IDLE -> ISSUE -> (WAIT) -> DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Which requester owns the memory for the access in flight.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_t;

  localparam int DW_DEFAULT  = 32;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  // Latency counter preload; out-of-range latencies are clamped to the legal range.
  function automatic logic [CNT_W-1:0] lat_cnt_init(input int lat);
    int l;
    l = lat;
    if (l < MEM_LAT_MIN) begin
      l = MEM_LAT_MIN;
    end else if (l > MEM_LAT_MAX) begin
      l = MEM_LAT_MAX;
    end else begin
      l = lat;
    end
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/minimips_dmem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the loader port and the data memory.
interface minimips_dmem_arbiter_if
  import minimips_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = DW_DEFAULT
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_done;
  logic [DW-1:0] ldr_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_done, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_done, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/minimips_dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick between CPU and loader with a last-grant register.
module minimips_rr_arb2
  import minimips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic update,
  output logic grant_valid,
  output req_t grant
);

  req_t last_grant_r;

  // Pick the winner; on a tie the requester that did not win last time goes.
  always_comb begin
    grant_valid = cpu_req | ldr_req;
    grant       = REQ_CPU;
    if (cpu_req && ldr_req) begin
      if (last_grant_r == REQ_LDR) begin
        grant = REQ_CPU;
      end else begin
        grant = REQ_LDR;
      end
    end else if (ldr_req) begin
      grant = REQ_LDR;
    end else begin
      grant = REQ_CPU;
    end
  end

  // Remember the last winner; reset favours the CPU on the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= REQ_LDR;
    end else if (update) begin
      last_grant_r <= grant;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/minimips_dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the loader port,
// sequencing each access through a fixed-latency synchronous memory.
module minimips_dmem_arbiter
  import minimips_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = DW_DEFAULT,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  minimips_dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = lat_cnt_init(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  req_t             owner_r;
  logic             grant_valid_s;
  req_t             grant_s;
  logic             update_s;
  logic             done_go_s;
  logic             sel_we_s;
  logic [AW-1:0]    sel_addr_s;
  logic [DW-1:0]    sel_wdata_s;

  logic             mem_en_r;
  logic             mem_we_r;
  logic [AW-1:0]    mem_addr_r;
  logic [DW-1:0]    mem_wdata_r;
  logic             cpu_done_r;
  logic             ldr_done_r;
  logic [DW-1:0]    cpu_rdata_r;
  logic [DW-1:0]    ldr_rdata_r;

  minimips_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (bus.cpu_req),
    .ldr_req     (bus.ldr_req),
    .update      (update_s),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Requests are only looked at in IDLE; DONE is entered for exactly one cycle.
  assign update_s  = (state_r == IDLE) && grant_valid_s;
  assign done_go_s = (state_s == DONE);

  // Next-state logic for the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (CNT_INIT == CNT_ZERO) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Winner's fields, muxed so they can be captured on the grant edge.
  always_comb begin
    if (grant_s == REQ_LDR) begin
      sel_we_s    = bus.ldr_we;
      sel_addr_s  = bus.ldr_addr;
      sel_wdata_s = bus.ldr_wdata;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      case (state_r)
        ISSUE:   cnt_r <= CNT_INIT;
        WAIT:    cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Memory strobe, captured access fields, done pulses and read-data holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_r     <= REQ_CPU;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      cpu_done_r  <= 1'b0;
      ldr_done_r  <= 1'b0;
      cpu_rdata_r <= {DW{1'b0}};
      ldr_rdata_r <= {DW{1'b0}};
    end else begin
      mem_en_r <= update_s;
      if (update_s) begin
        owner_r     <= grant_s;
        mem_we_r    <= sel_we_s;
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
      end
      cpu_done_r <= done_go_s && (owner_r == REQ_CPU);
      ldr_done_r <= done_go_s && (owner_r == REQ_LDR);
      // Load data is taken on the edge entering DONE so it is valid with done.
      if (done_go_s && !mem_we_r) begin
        if (owner_r == REQ_CPU) begin
          cpu_rdata_r <= bus.mem_rdata;
        end else begin
          ldr_rdata_r <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_done  = cpu_done_r;
  assign bus.ldr_done  = ldr_done_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.ldr_rdata = ldr_rdata_r;
  // The core must freeze in the same cycle it raises a request.
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_r;

endmodule
